lsu_mem_master: RTL and testbench
=================================

Name: lsu_mem_master

Overview:
- Load/store initiator between the integer core's EX/MEM stage and the byte-addressed, little-endian data memory.
- Accepts one RV32I load or store request at a time and drives the memory's address, write_data, read and write strobes.
- Memory supports whole-word access only, so LB/LBU/LH/LHU are extracted from a word read; SB/SH are done as read-modify-write.
- Returns sign- or zero-extended load data, or an error for misaligned, out-of-range or illegal requests.

Parameters:
- MEM_RD_LAT, 1, cycles mem_read is held before mem_read_data is sampled (range 1..4).
- DM_BYTES, 64, memory size in bytes; any word base at or above DM_BYTES-3 is out of range.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  high only in IDLE with reset high; transfer occurs when req_valid and req_ready are both high.
- is_store  input  1  1 = store, 0 = load.
- funct3  input  3  RV32I width/sign code: 0 B, 1 H, 2 W, 4 BU, 5 HU.
- addr  input  32  byte address.
- store_data  input  32  store source; low byte or halfword used for SB/SH.
- resp_valid  output  1  one-cycle completion pulse; no backpressure.
- resp_err  output  1  qualifies resp_valid; 1 = fault.
- load_data  output  32  extended load result, valid with resp_valid; 0 on stores and faults.
- mem_address  output  32  word-aligned address: {addr[31:2],2'b00}.
- mem_write_data  output  32  word written to memory.
- mem_read  output  1  read strobe.
- mem_write  output  1  write strobe.
- mem_read_data  input  32  word returned by memory.

Behaviour:
- Reset (reset=0 at a clk edge):
  - State goes to IDLE; all outputs registered to 0, including req_ready.
  - Any in-flight operation is aborted: strobes drop at that edge and no response is issued.
- States: IDLE, RD, WR, RESP.
- On IDLE acceptance, addr, funct3, is_store and store_data are latched. Fault check uses the latched values:
  - Misaligned: H/HU/SH with addr[0]=1, or W/SW with addr[1:0]!=0.
  - Out of range: {addr[31:2],2'b00}+3 >= DM_BYTES.
  - Illegal funct3: loads with 3/6/7; stores with anything other than 0/1/2.
  - On a fault: IDLE -> RESP with resp_err=1; mem_read and mem_write never assert.
- LW/LB/LBU/LH/LHU: IDLE -> RD.
  - RD holds mem_read=1 for MEM_RD_LAT cycles; mem_read_data is captured on the last RD cycle.
  - RD -> RESP.
  - Latency with MEM_RD_LAT=1: accept at edge 0, resp_valid in cycle 2.
- SW: IDLE -> WR.
  - WR is one cycle with mem_write=1 and mem_write_data=store_data.
  - WR -> RESP; resp_valid in cycle 2.
- SB/SH: IDLE -> RD -> WR -> RESP.
  - The read word is merged: SB replaces byte lane addr[1:0]; SH replaces lanes {addr[1],0} and {addr[1],1}.
  - The merged word is written in WR.
  - resp_valid in cycle MEM_RD_LAT+2.
- Load extract:
  - Byte = word >> (8*addr[1:0]); halfword = word >> (16*addr[1]).
  - B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes the word unchanged.
- RESP is one cycle: resp_valid=1, then return to IDLE.
  - req_ready reasserts the cycle after RESP, so peak rate is one request per 3 cycles (SW).
- Strobes are mutually exclusive; mem_read and mem_write are never both 1.
- mem_address is stable for the whole RD..WR span of one request.
- req_valid is ignored outside IDLE; the request is not queued.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants F3_B/H/W/BU/HU.
  - State enum lsu_state_t.
  - DM_BYTES default value.
- Sub-module lsu_align (combinational):
  - Inputs: word, addr[1:0], funct3, store_data.
  - Outputs: extended load value, merged store word, misalign flag.
- The FSM, counter and registers stay in lsu_mem_master.

Test Plan:
- Memory word 0x8C7B6A59 at address 8 (MEM_RD_LAT=1); LW addr 8 -> mem_read high in cycle 1 only, resp_valid in cycle 2, load_data=0x8C7B6A59, resp_err=0.
- Same word; LB addr 11 -> 0xFFFFFF8C; LBU addr 11 -> 0x0000008C; LH addr 10 -> 0xFFFF8C7B; LHU addr 8 -> 0x00006A59.
- SB addr 9 with store_data=0x000000EE over word 0x8C7B6A59 -> RD then WR with mem_write_data=0x8C7BEE59, resp_valid in cycle 3; a following LW addr 8 returns 0x8C7BEE59.
- LW addr 6, SH addr 5, LW addr 64, load with funct3=3 -> each gives resp_valid with resp_err=1 and load_data=0; mem_read and mem_write stay 0 throughout.
- MEM_RD_LAT=3: LW -> mem_read high for exactly 3 cycles, resp_valid in cycle 4; req_ready low from the accept edge until after RESP.
- Drive reset=0 during the RD cycle of an SB -> no mem_write and no resp_valid; outputs are 0 after the edge; req_ready=1 one cycle after reset returns high.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store initiator: funct3 codes, FSM states,
// default memory size and the funct3 legality helper.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam int LSU_DM_BYTES = 64;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RESP
  } lsu_state_t;

  // Stores only exist as SB/SH/SW; loads reject the three unused codes.
  function automatic logic f3_illegal(input logic st, input logic [2:0] f3);
    if (st) return !(f3 inside {F3_B, F3_H, F3_W});
    return f3 inside {3'd3, 3'd6, 3'd7};
  endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// Word-wide data memory bus: the LSU drives address/strobes/write data,
// the memory returns the read word.
interface lsu_mem_master_if;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_read_data;

  modport master (
    output mem_address, mem_write_data, mem_read, mem_write,
    input  mem_read_data
  );

  modport slave (
    input  mem_address, mem_write_data, mem_read, mem_write,
    output mem_read_data
  );
endinterface

// File: rtl/lsu_align.sv
// Sub-word lane handling: load extraction with extension, read-modify-write
// merge for SB/SH, and the alignment check.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  input  logic [31:0] store_data,
  output logic [31:0] load_val,
  output logic [31:0] merged,
  output logic        misalign
);

  logic [7:0]         b;
  logic [15:0]        h;
  logic signed [7:0]  b_s;
  logic signed [15:0] h_s;

  assign b   = 8'(word >> {lane, 3'b000});
  assign h   = 16'(word >> {lane[1], 4'b0000});
  assign b_s = signed'(b);
  assign h_s = signed'(h);

  always_comb begin
    load_val = '0;
    case (funct3)
      F3_B:    load_val = 32'(b_s);
      F3_H:    load_val = 32'(h_s);
      F3_W:    load_val = word;
      F3_BU:   load_val = 32'(b);
      F3_HU:   load_val = 32'(h);
      default: load_val = '0;
    endcase
  end

  always_comb begin
    merged = word;
    case (funct3)
      F3_B:    merged[{lane, 3'b000} +: 8]     = store_data[7:0];
      F3_H:    merged[{lane[1], 4'b0000} +: 16] = store_data[15:0];
      F3_W:    merged = store_data;
      default: merged = word;
    endcase
  end

  assign misalign = (((funct3 == F3_H) || (funct3 == F3_HU)) && lane[0]) ||
                    ((funct3 == F3_W) && (lane != 2'b00));

endmodule

// File: rtl/lsu_mem_master.sv
// Single-outstanding RV32I load/store initiator for a word-only memory.
// All outputs are registered; sub-word stores are done as read-modify-write.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int MEM_RD_LAT = 1,
  parameter int DM_BYTES   = LSU_DM_BYTES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       store_data,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       load_data,
  lsu_mem_master_if.master  mem
);

  lsu_state_t  state_q, state_nxt;
  logic [2:0]  cnt_q, cnt_nxt;
  logic        req_ready_q, req_ready_nxt;
  logic        resp_valid_q, resp_valid_nxt;
  logic        resp_err_q, resp_err_nxt;
  logic [31:0] load_data_q, load_data_nxt;
  logic [31:0] mem_address_q, mem_address_nxt;
  logic [31:0] mem_wdata_q, mem_wdata_nxt;
  logic        mem_read_q, mem_read_nxt;
  logic        mem_write_q, mem_write_nxt;

  logic [1:0]  lane_p0;
  logic [2:0]  f3_p0;
  logic        st_p0;
  logic [31:0] sd_p0;

  logic        accept;
  logic [31:0] word_addr;
  logic        out_of_range;
  logic [1:0]  lane_sel;
  logic [2:0]  f3_sel;
  logic [31:0] load_val;
  logic [31:0] merged;
  logic        misalign;
  logic        fault;

  assign accept       = req_valid && req_ready_q;
  assign word_addr    = {addr[31:2], 2'b00};
  assign out_of_range = (word_addr + 32'd3) >= 32'(DM_BYTES);

  // The aligner checks the incoming request in IDLE and the latched one after.
  assign lane_sel = (state_q == S_IDLE) ? addr[1:0] : lane_p0;
  assign f3_sel   = (state_q == S_IDLE) ? funct3    : f3_p0;
  assign fault    = misalign || out_of_range || f3_illegal(is_store, funct3);

  lsu_align u_align (
    .word       (mem.mem_read_data),
    .lane       (lane_sel),
    .funct3     (f3_sel),
    .store_data (sd_p0),
    .load_val   (load_val),
    .merged     (merged),
    .misalign   (misalign)
  );

  // Request capture stage
  always_ff @(posedge clk) begin
    if (accept) begin
      lane_p0 <= addr[1:0];
      f3_p0   <= funct3;
      st_p0   <= is_store;
      sd_p0   <= store_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      req_ready_q   <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_err_q    <= 1'b0;
      load_data_q   <= '0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
    end else begin
      state_q       <= state_nxt;
      cnt_q         <= cnt_nxt;
      req_ready_q   <= req_ready_nxt;
      resp_valid_q  <= resp_valid_nxt;
      resp_err_q    <= resp_err_nxt;
      load_data_q   <= load_data_nxt;
      mem_address_q <= mem_address_nxt;
      mem_wdata_q   <= mem_wdata_nxt;
      mem_read_q    <= mem_read_nxt;
      mem_write_q   <= mem_write_nxt;
    end
  end

  always_comb begin
    state_nxt       = state_q;
    cnt_nxt         = cnt_q;
    req_ready_nxt   = 1'b0;
    resp_valid_nxt  = 1'b0;
    resp_err_nxt    = 1'b0;
    load_data_nxt   = '0;
    mem_address_nxt = mem_address_q;
    mem_wdata_nxt   = mem_wdata_q;
    mem_read_nxt    = 1'b0;
    mem_write_nxt   = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready_nxt = 1'b1;
        if (accept) begin
          req_ready_nxt = 1'b0;
          if (fault) begin
            state_nxt      = S_RESP;
            resp_valid_nxt = 1'b1;
            resp_err_nxt   = 1'b1;
          end else if (is_store && (funct3 == F3_W)) begin
            state_nxt       = S_WR;
            mem_write_nxt   = 1'b1;
            mem_wdata_nxt   = store_data;
            mem_address_nxt = word_addr;
          end else begin
            state_nxt       = S_RD;
            mem_read_nxt    = 1'b1;
            cnt_nxt         = '0;
            mem_address_nxt = word_addr;
          end
        end
      end
      S_RD: begin
        mem_read_nxt = 1'b1;
        if (cnt_q == 3'(MEM_RD_LAT - 1)) begin
          mem_read_nxt = 1'b0;
          if (st_p0) begin
            state_nxt     = S_WR;
            mem_write_nxt = 1'b1;
            mem_wdata_nxt = merged;
          end else begin
            state_nxt      = S_RESP;
            resp_valid_nxt = 1'b1;
            load_data_nxt  = load_val;
          end
        end else begin
          cnt_nxt = cnt_q + 3'd1;
        end
      end
      S_WR: begin
        state_nxt      = S_RESP;
        resp_valid_nxt = 1'b1;
      end
      S_RESP: begin
        state_nxt     = S_IDLE;
        req_ready_nxt = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign req_ready          = req_ready_q;
  assign resp_valid         = resp_valid_q;
  assign resp_err           = resp_err_q;
  assign load_data          = load_data_q;
  assign mem.mem_address    = mem_address_q;
  assign mem.mem_write_data = mem_wdata_q;
  assign mem.mem_read       = mem_read_q;
  assign mem.mem_write      = mem_write_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Drives the same request stream into two LSUs (read latency 1 and 3), each
// with its own memory model; responses are matched against per-DUT queues.
module tb_lsu_mem_master;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        req_ready_a, resp_valid_a, resp_err_a;
  logic        req_ready_b, resp_valid_b, resp_err_b;
  logic [31:0] load_data_a, load_data_b;

  int errors = 0;
  int checks = 0;
  logic [32:0] sb_a[$];
  logic [32:0] sb_b[$];
  logic [31:0] mem_a [16];
  logic [31:0] mem_b [16];

  lsu_mem_master_if mif_a ();
  lsu_mem_master_if mif_b ();

  always #5 clk = ~clk;

  lsu_mem_master #(.MEM_RD_LAT(1), .DM_BYTES(64)) dut_a (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_a),
    .is_store(is_store), .funct3(funct3), .addr(addr), .store_data(store_data),
    .resp_valid(resp_valid_a), .resp_err(resp_err_a), .load_data(load_data_a),
    .mem(mif_a)
  );

  lsu_mem_master #(.MEM_RD_LAT(3), .DM_BYTES(64)) dut_b (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_b),
    .is_store(is_store), .funct3(funct3), .addr(addr), .store_data(store_data),
    .resp_valid(resp_valid_b), .resp_err(resp_err_b), .load_data(load_data_b),
    .mem(mif_b)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 2) return 32'h8C7B6A59;
    return {8'(i), 8'hA5, 8'(i * 3), 8'h3C};
  endfunction

  // Memory models reload their contents whenever reset is held.
  assign mif_a.mem_read_data = mem_a[mif_a.mem_address[5:2]];
  assign mif_b.mem_read_data = mem_b[mif_b.mem_address[5:2]];

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) begin
        mem_a[i] <= init_word(i);
        mem_b[i] <= init_word(i);
      end
    end else begin
      if (mif_a.mem_write) mem_a[mif_a.mem_address[5:2]] <= mif_a.mem_write_data;
      if (mif_b.mem_write) mem_b[mif_b.mem_address[5:2]] <= mif_b.mem_write_data;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && resp_valid_a) begin
      if (sb_a.size() == 0) check_eq("sb_a_unexpected_resp", 1, 0);
      else check_eq("resp_a", {resp_err_a, load_data_a}, sb_a.pop_front());
    end
    if (reset && resp_valid_b) begin
      if (sb_b.size() == 0) check_eq("sb_b_unexpected_resp", 1, 0);
      else check_eq("resp_b", {resp_err_b, load_data_b}, sb_b.pop_front());
    end
  end

  task automatic run_req(input string name, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd,
                         input logic err, input logic [31:0] exp_d,
                         input int lat, input int rd, input int wr,
                         input logic [31:0] exp_wd);
    int n, lat_a, lat_b, rd_a, rd_b, wr_a, wr_b, rdy_a, rdy_b, both;
    logic done_a, done_b;
    logic [31:0] wd_a, wd_b;
    n = 0;
    @(negedge clk);
    while (!(req_ready_a && req_ready_b) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check_eq({name, ".ready_timeout"}, 0, 1);
    is_store = st; funct3 = f3; addr = a; store_data = sd; req_valid = 1'b1;
    sb_a.push_back({err, exp_d});
    sb_b.push_back({err, exp_d});
    @(posedge clk);
    #1 req_valid = 1'b0;
    {lat_a, lat_b, rd_a, rd_b, wr_a, wr_b, rdy_a, rdy_b, both} = '0;
    done_a = 1'b0; done_b = 1'b0; wd_a = '0; wd_b = '0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (!done_a) begin
        if (mif_a.mem_read) rd_a++;
        if (mif_a.mem_write) begin wr_a++; wd_a = mif_a.mem_write_data; end
        if (req_ready_a) rdy_a++;
        if (resp_valid_a) begin done_a = 1'b1; lat_a = cyc; end
      end
      if (!done_b) begin
        if (mif_b.mem_read) rd_b++;
        if (mif_b.mem_write) begin wr_b++; wd_b = mif_b.mem_write_data; end
        if (req_ready_b) rdy_b++;
        if (resp_valid_b) begin done_b = 1'b1; lat_b = cyc; end
      end
      if ((mif_a.mem_read && mif_a.mem_write) || (mif_b.mem_read && mif_b.mem_write)) both++;
      if (done_a && done_b) break;
    end
    if (!(done_a && done_b)) check_eq({name, ".resp_timeout"}, {done_a, done_b}, 2'b11);
    check_eq({name, ".lat_a"}, lat_a, lat);
    check_eq({name, ".lat_b"}, lat_b, (rd > 0) ? lat + 2 : lat);
    check_eq({name, ".rd_a"}, rd_a, rd);
    check_eq({name, ".rd_b"}, rd_b, (rd > 0) ? 3 : 0);
    check_eq({name, ".wr_ab"}, {wr_a, wr_b}, {wr, wr});
    check_eq({name, ".ready_busy"}, {rdy_a, rdy_b}, 64'd0);
    check_eq({name, ".strobe_excl"}, both, 0);
    if (wr > 0) check_eq({name, ".wdata"}, {wd_a, wd_b}, {exp_wd, exp_wd});
  endtask

  initial begin
    int n;
    reset = 1'b0; req_valid = 1'b0; is_store = 1'b0; funct3 = '0;
    addr = '0; store_data = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_ctl", {req_ready_a, resp_valid_a, resp_err_a, mif_a.mem_read,
             mif_a.mem_write, req_ready_b, resp_valid_b, mif_b.mem_read, mif_b.mem_write}, 0);
    check_eq("reset_data", {load_data_a, mif_a.mem_address, mif_a.mem_write_data}, 0);
    reset = 1'b1;
    @(negedge clk);
    check_eq("ready_after_reset", {req_ready_a, req_ready_b}, 2'b11);

    run_req("lw8",   0, F3_W,  32'd8,  0, 0, 32'h8C7B6A59, 2, 1, 0, 0);
    run_req("lb11",  0, F3_B,  32'd11, 0, 0, 32'hFFFFFF8C, 2, 1, 0, 0);
    run_req("lbu11", 0, F3_BU, 32'd11, 0, 0, 32'h0000008C, 2, 1, 0, 0);
    run_req("lh10",  0, F3_H,  32'd10, 0, 0, 32'hFFFF8C7B, 2, 1, 0, 0);
    run_req("lhu8",  0, F3_HU, 32'd8,  0, 0, 32'h00006A59, 2, 1, 0, 0);
    run_req("sb9",   1, F3_B,  32'd9,  32'h000000EE, 0, 0, 3, 1, 1, 32'h8C7BEE59);
    run_req("lw8b",  0, F3_W,  32'd8,  0, 0, 32'h8C7BEE59, 2, 1, 0, 0);
    run_req("sw12",  1, F3_W,  32'd12, 32'h11223344, 0, 0, 2, 0, 1, 32'h11223344);
    run_req("sh14",  1, F3_H,  32'd14, 32'hCAFEBEEF, 0, 0, 3, 1, 1, 32'hBEEF3344);
    run_req("lw12",  0, F3_W,  32'd12, 0, 0, 32'hBEEF3344, 2, 1, 0, 0);
    run_req("lh14",  0, F3_H,  32'd14, 0, 0, 32'hFFFFBEEF, 2, 1, 0, 0);
    run_req("lw60",  0, F3_W,  32'd60, 0, 0, init_word(15), 2, 1, 0, 0);
    run_req("lw6",   0, F3_W,  32'd6,  0, 1, 0, 1, 0, 0, 0);
    run_req("sh5",   1, F3_H,  32'd5,  32'h1234, 1, 0, 1, 0, 0, 0);
    run_req("lw64",  0, F3_W,  32'd64, 0, 1, 0, 1, 0, 0, 0);
    run_req("ld_f3", 0, 3'd3,  32'd8,  0, 1, 0, 1, 0, 0, 0);
    run_req("st_f4", 1, F3_BU, 32'd8,  0, 1, 0, 1, 0, 0, 0);

    // Abort an SB in its read cycle.
    n = 0;
    @(negedge clk);
    while (!(req_ready_a && req_ready_b) && n < 20) begin @(negedge clk); n++; end
    is_store = 1'b1; funct3 = F3_B; addr = 32'd9; store_data = 32'h11; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check_eq("abort_in_rd", {mif_a.mem_read, mif_b.mem_read}, 2'b11);
    reset = 1'b0;
    @(negedge clk);
    check_eq("abort_ctl", {req_ready_a, resp_valid_a, mif_a.mem_read, mif_a.mem_write,
             req_ready_b, resp_valid_b, mif_b.mem_read, mif_b.mem_write}, 0);
    check_eq("abort_data", {load_data_a, mif_a.mem_address, mif_b.mem_address}, 0);
    reset = 1'b1;
    @(negedge clk);
    check_eq("abort_ready", {req_ready_a, req_ready_b}, 2'b11);
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (mif_a.mem_write || mif_b.mem_write || resp_valid_a || resp_valid_b) n++;
    end
    check_eq("abort_quiet", n, 0);
    run_req("lw8_post", 0, F3_W, 32'd8, 0, 0, 32'h8C7B6A59, 2, 1, 0, 0);

    repeat (3) @(negedge clk);
    check_eq("sb_drained", {sb_a.size(), sb_b.size()}, 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
